regfile_sb: RTL
===============

# regfile_sb

Parametrised general-purpose register file with a per-register busy scoreboard, replacing single 8-bit enable registers in the processor datapath. It provides one byte-maskable write port, two combinational read ports with optional write-to-read bypass, and busy tracking so the decode stage can stall on registers with pending writebacks.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 32, number of registers; must be a power of two, at least 2
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to read data and busy outputs
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- waddr  in  AW = $clog2(DEPTH)  write register index
- wdata  in  WIDTH  write data
- wstrb  in  WIDTH/8  byte strobes; bit i enables wdata[8i+7:8i]
- raddr_a, raddr_b  in  AW  read indices
- rdata_a, rdata_b  out  WIDTH  read data, combinational
- issue_valid  in  1  an instruction targeting issue_rd has issued
- issue_rd  in  AW  destination register of the issued instruction
- flush  in  1  synchronous clear of all busy bits
- busy_a, busy_b  out  1  busy status of raddr_a and raddr_b, combinational

## Operation
- Storage: DEPTH x WIDTH register array plus a DEPTH-bit busy vector.
- Write: on a rising edge with we=1, each byte of regs[waddr] whose wstrb bit is 1 takes the wdata byte. Other bytes hold. we=1 with wstrb=0 changes no data.
- Writeback clear: we=1 clears busy[waddr] on the same edge, regardless of wstrb.
- Issue: issue_valid=1 sets busy[issue_rd] on the edge.
- Same-register set and clear on one edge (issue_rd==waddr, both valid): set wins, so busy=1. This covers a new producer issuing as the old one retires.
- flush=1 clears every busy bit on the edge. It overrides issue and clear in that cycle. Register data writes still occur.
- ZERO_REG=1: writes, issues and busy-set to index 0 are dropped. rdata for index 0 is 0 and busy for index 0 is 0, including under bypass.
- Read, BYPASS=0: rdata_x = regs[raddr_x] and busy_x = busy[raddr_x], both pre-edge state.
- Read, BYPASS=1 with we=1 and waddr==raddr_x:
  - rdata_x is regs[raddr_x] with the strobed wdata bytes merged in.
  - busy_x = 0, unless flush is 0 and issue_valid is 1 in the same cycle to the same register. Busy still reports pre-edge state in that case, since issue only takes effect after the edge.
- Ports a and b are independent and may carry equal addresses.

## Timing
- Reset (rst=0, async): all registers 0, all busy bits 0. So rdata_a, rdata_b, busy_a and busy_b are 0 while reset is held. Inputs are ignored until rst is released.
- Reset asserted mid-write: the write is lost and the register reads 0.
- Write latency: 1 edge, or visible in the same cycle with BYPASS=1.
- Read latency: 0 cycles, combinational from raddr.
- Busy set latency: busy_x reads 1 starting the cycle after the issue edge.
- Busy clear latency: 1 edge, or the same cycle with BYPASS=1.
- No handshake. Every input is sampled every edge and there are no stalls inside the block.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst low asynchronously mid-cycle -> rdata for r5 is 0 immediately, busy for r5 is 0.
- Byte strobes: r3=0x11223344; write wdata=0xAABBCCDD with wstrb=4'b0101 -> r3 reads 0x11BB33DD next cycle. With BYPASS=1 the merged value is visible in the same cycle.
- Zero register: write 0xFFFFFFFF to r0 and issue r0 -> rdata_a=0 and busy_a=0 with raddr_a=0. With ZERO_REG=0, r0 reads 0xFFFFFFFF and busy=1.
- Scoreboard: issue r7 -> busy_a=1 from the next cycle. Writeback to r7 -> busy_a=0 in the same cycle (BYPASS=1) or the next cycle (BYPASS=0). Issue r7 and writeback r7 on the same edge -> busy stays 1.
- Flush: issue r1, r2 and r9 on three consecutive cycles, then flush=1 with issue_valid=1 to r4 -> all busy bits 0 next cycle, including r4.
- Dual-port aliasing: raddr_a=raddr_b=r12 during a write of 0x0000CAFE to r12 with full strobes -> both rdata outputs are equal. Both are 0x0000CAFE with BYPASS=1, or the old value with BYPASS=0.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with byte-masked write, two bypassed read ports and a
// per-register busy scoreboard for decode-stage stall detection.
module regfile_sb #(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  DEPTH    = 32,
    parameter bit           ZERO_REG = 1'b1,
    parameter bit           BYPASS   = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned NB       = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [NB-1:0]    wstrb,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             flush,
    output logic             busy_a,
    output logic             busy_b
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_en;
    logic             iss_en;

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [NB-1:0]    strb
    );
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < int'(NB); i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    assign wr_en  = we && !(ZERO_REG && waddr == '0);
    assign iss_en = issue_valid && !(ZERO_REG && issue_rd == '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[waddr] = merge(regs_q[waddr], wdata, wstrb);
    end

    // Set after clear so a producer issuing as the old one retires wins.
    always_comb begin
        busy_d = busy_q;
        if (we) busy_d[waddr] = 1'b0;
        if (iss_en) busy_d[issue_rd] = 1'b1;
        if (flush) busy_d = '0;
        if (ZERO_REG) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] res;
        res = regs_q[ra];
        if (BYPASS && we && waddr == ra) res = merge(regs_q[ra], wdata, wstrb);
        if ((ZERO_REG && ra == '0) || !rst) res = '0;
        return res;
    endfunction

    // A same-cycle reissue keeps the pre-edge busy value visible.
    function automatic logic rd_busy(input logic [AW-1:0] ra);
        logic res;
        logic reissue;
        res     = busy_q[ra];
        reissue = !flush && iss_en && issue_rd == ra;
        if (BYPASS && we && waddr == ra && !reissue) res = 1'b0;
        if ((ZERO_REG && ra == '0) || !rst) res = 1'b0;
        return res;
    endfunction

    assign rdata_a = rd_data(raddr_a);
    assign rdata_b = rd_data(raddr_b);
    assign busy_a  = rd_busy(raddr_a);
    assign busy_b  = rd_busy(raddr_b);

endmodule
